// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage
//
// Owns the fetch PC and issues word fetches to instruction memory over a
// req/gnt/rvalid handshake. Returned words are buffered in a small in-order
// FIFO and handed to decode as {inst, inst_addr} with valid/ready. A redirect
// from execute retargets the PC, flushes the FIFO and arranges for every
// response still in flight to be dropped on arrival.
//
// Optional feature (macro IF_PERF_CNT_EN): adds the fetch_cnt / redirect_cnt
// performance counter outputs. With the macro undefined the ports are absent
// and the core behaviour is identical.
//
// Parameters
//   RESET_PC       first fetch address after reset
//   FIFO_DEPTH     instruction buffer entries (power of 2, >= 2); also caps
//                  outstanding plus buffered fetches
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous reset, active-high
//   imem_req       fetch request valid
//   imem_addr      fetch address (word aligned)
//   imem_gnt       request accepted this cycle (only meaningful with imem_req)
//   imem_rvalid    read data valid, one per grant, in order
//   imem_rdata     returned instruction word
//   redirect_valid redirect this cycle
//   redirect_pc    redirect target (low two bits ignored)
//   id_valid       inst/inst_addr valid to decode
//   id_ready       decode accepts
//   inst           instruction word at the FIFO head
//   inst_addr      PC of inst
//   fetch_cnt      (IF_PERF_CNT_EN) instructions accepted by decode
//   redirect_cnt   (IF_PERF_CNT_EN) redirect cycles seen
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] inst,
`ifdef IF_PERF_CNT_EN
  output logic [63:0] inst_addr,
  output logic [63:0] fetch_cnt,
  output logic [63:0] redirect_cnt
`else
  output logic [63:0] inst_addr
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [63:0]      fetch_pc;      // next address to request
  logic [63:0]      resp_pc;       // PC of the next response that is kept
  logic [CNT_W-1:0] outstanding;   // granted but not yet returned
  logic [CNT_W-1:0] drop_cnt;      // in-flight responses belonging to a dead stream
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic [31:0]      inst_mem [FIFO_DEPTH];
  logic [63:0]      addr_mem [FIFO_DEPTH];

  // Last popped entry, shown to decode while the FIFO is empty.
  logic [31:0]      last_inst;
  logic [63:0]      last_addr;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W:0]   inflight;
  logic             grant;
  logic             drop;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] outstanding_resp;
  logic [CNT_W-1:0] outstanding_next;
  logic [63:0]      redirect_target;

  // NOTE: every signal in an always_comb gets a default assignment before any
  // conditional logic, so no path can leave it unassigned and infer a latch.
  always_comb begin
    fifo_empty       = (fifo_count == '0);
    fifo_full        = (fifo_count == CNT_W'(FIFO_DEPTH));
    inflight         = {1'b0, outstanding} + {1'b0, fifo_count};
    redirect_target  = redirect_pc & ~64'd3;

    // Throttle: never have more fetches alive than the FIFO can absorb, so a
    // kept response always finds a free slot.
    imem_req         = ~rst & ~redirect_valid & (inflight < (CNT_W + 1)'(FIFO_DEPTH));
    grant            = imem_req & imem_gnt;

    drop             = imem_rvalid & (drop_cnt != '0);
    push             = imem_rvalid & ~drop & ~redirect_valid;

    id_valid         = ~rst & ~fifo_empty & ~redirect_valid;
    pop              = id_valid & id_ready;

    // Response accounting happens before the redirect samples the count, so a
    // response arriving in the redirect cycle is not counted as still pending.
    outstanding_resp = outstanding - CNT_W'(imem_rvalid);
    outstanding_next = outstanding_resp + CNT_W'(grant);
  end

  assign imem_addr = fetch_pc;

  always_comb begin
    inst      = '0;
    inst_addr = '0;
    if (!rst) begin
      if (fifo_empty) begin
        inst      = last_inst;
        inst_addr = last_addr;
      end else begin
        inst      = inst_mem[rd_ptr];
        inst_addr = addr_mem[rd_ptr];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // PC, counters and FIFO pointers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values, independent of process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      last_inst   <= '0;
      last_addr   <= '0;
    end else begin
      outstanding <= outstanding_next;

      if (redirect_valid) begin
        // Redirect wins over everything: new stream, empty buffer, and every
        // response still in flight belongs to the old stream.
        fetch_pc   <= redirect_target;
        resp_pc    <= redirect_target;
        drop_cnt   <= outstanding_resp;
        fifo_count <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + 64'd4;
        end
        if (drop) begin
          drop_cnt <= drop_cnt - CNT_W'(1);
        end
        if (push) begin
          resp_pc <= resp_pc + 64'd4;
          wr_ptr  <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr    <= rd_ptr + PTR_W'(1);
          last_inst <= inst_mem[rd_ptr];
          last_addr <= addr_mem[rd_ptr];
        end
        fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // NOTE: the buffer storage has no reset; fifo_count gates every read, so
  // stale contents are never visible and the array can map to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= imem_rdata;
      addr_mem[wr_ptr] <= resp_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (pop) begin
        fetch_cnt <= fetch_cnt + 64'd1;
      end
      if (redirect_valid) begin
        redirect_cnt <= redirect_cnt + 64'd1;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------
  // The request throttle makes a push into a full, non-draining FIFO impossible
  // unless the memory returns data it was never asked for.
  overflow_check : assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full && !pop));

  spurious_rvalid_check : assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage
//
// A behavioural instruction memory grants every request (when enabled) and
// returns a word derived from the address after a programmable latency. A
// monitor records every {inst_addr, inst} accepted by decode; directed
// sequences and a table of redirect vectors compare against hand-derived
// addresses. Define IF_PERF_CNT_EN to also check the performance counters.
// -----------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt    = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = '0;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] inst;
  logic [63:0] inst_addr;
`ifdef IF_PERF_CNT_EN
  logic [63:0] fetch_cnt;
  logic [63:0] redirect_cnt;
`endif

  if_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .inst           (inst),
`ifdef IF_PERF_CNT_EN
    .inst_addr      (inst_addr),
    .fetch_cnt      (fetch_cnt),
    .redirect_cnt   (redirect_cnt)
`else
    .inst_addr      (inst_addr)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Word stored at a given address in the memory model.
  function automatic logic [31:0] word_at(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------------------------------------------------------------------
  // Memory model and decode monitor
  // ---------------------------------------------------------------------------
  int          cyc    = 0;
  int          lat    = 1;
  bit          gnt_en = 1'b1;
  logic [63:0] pq_addr [$];   // granted, response not yet returned
  int          pq_due  [$];
  logic [63:0] gq      [$];   // every granted address
  logic [63:0] dq_addr [$];   // every accepted inst_addr
  logic [31:0] dq_inst [$];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      pq_addr.delete();
      pq_due.delete();
    end else begin
      if (imem_rvalid) begin
        void'(pq_addr.pop_front());
        void'(pq_due.pop_front());
      end
      if (imem_req && imem_gnt) begin
        pq_addr.push_back(imem_addr);
        pq_due.push_back(cyc + lat);
        gq.push_back(imem_addr);
      end
      if (id_valid && id_ready) begin
        dq_addr.push_back(inst_addr);
        dq_inst.push_back(inst);
      end
    end
  end

  always @(negedge clk) begin
    imem_gnt = gnt_en;
    if (pq_addr.size() > 0 && pq_due[0] <= cyc + 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_at(pq_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic clear_logs();
    gq.delete();
    dq_addr.delete();
    dq_inst.delete();
  endtask

  // Holds reset over two rising edges, releases it at a falling edge and
  // returns 1 time unit later (the "cycle 0" of the new run).
  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    #1;
  endtask

  task automatic next_cycle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic expect_stream(input string name, input logic [63:0] start, input int n);
    logic [63:0] a;
    check({name, "_count"}, 64'(dq_addr.size() >= n), 64'd1);
    for (int i = 0; i < n && i < dq_addr.size(); i++) begin
      a = start + 64'(4 * i);
      check($sformatf("%s_addr%0d", name, i), dq_addr[i], a);
      check($sformatf("%s_inst%0d", name, i), 64'(dq_inst[i]), 64'(word_at(a)));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Redirect vectors: memory latency, target, expected aligned PC, and whether
  // the FIFO already holds an entry in the cycle the redirect is applied.
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    int          lat;
    logic [63:0] rpc;
    logic [63:0] exp_pc;
    logic        exp_idv_before;
  } redir_vec_t;

  redir_vec_t vecs [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"rd_lat3",  3, 64'h0000_0000_8000_1002, 64'h0000_0000_8000_1000, 1'b0};
    vecs[1] = '{"rd_lat1",  1, 64'h0000_0000_8000_1003, 64'h0000_0000_8000_1000, 1'b1};
    vecs[2] = '{"rd_wrap",  2, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};

    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;

    // ---- Reset state and basic streaming, 1-cycle memory ----
    repeat (2) @(negedge clk);
    #1;
    check("rst_req",       64'(imem_req),  64'd0);
    check("rst_id_valid",  64'(id_valid),  64'd0);
    check("rst_inst",      64'(inst),      64'd0);
    check("rst_inst_addr", inst_addr,      64'd0);
`ifdef IF_PERF_CNT_EN
    check("rst_fetch_cnt",    fetch_cnt,    64'd0);
    check("rst_redirect_cnt", redirect_cnt, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    #1;
    check("t1_req_first",  64'(imem_req), 64'd1);
    check("t1_addr_first", imem_addr,     RESET_PC);
    next_cycle(1);
    check("t1_idv_not_yet", 64'(id_valid), 64'd0);
    next_cycle(1);
    check("t1_idv_head",  64'(id_valid), 64'd1);
    check("t1_head_addr", inst_addr,     RESET_PC);
    check("t1_head_inst", 64'(inst),     64'(word_at(RESET_PC)));
    next_cycle(12);
    check("t1_grants", 64'(gq.size() >= 3), 64'd1);
    for (int i = 0; i < 3 && i < gq.size(); i++) begin
      check($sformatf("t1_grant%0d", i), gq[i], RESET_PC + 64'(4 * i));
    end
    expect_stream("t1", RESET_PC, 4);

    // ---- Decode stall: FIFO fills, request drops, nothing lost ----
    id_ready = 1'b0;
    do_reset();
    next_cycle(10);
    check("t2_req_low", 64'(imem_req),   64'd0);
    check("t2_grants",  64'(gq.size()),  64'(DEPTH));
    check("t2_idv",     64'(id_valid),   64'd1);
    check("t2_head",    inst_addr,       RESET_PC);
    gnt_en = 1'b0;
    next_cycle(1);
    id_ready = 1'b1;
    next_cycle(3);
    check("t2_empty_idv",  64'(id_valid), 64'd0);
    check("t2_hold_addr",  inst_addr,     RESET_PC + 64'd4);
    check("t2_hold_inst",  64'(inst),     64'(word_at(RESET_PC + 64'd4)));
    check("t2_req_wait",   64'(imem_req), 64'd1);
    check("t2_addr_wait",  imem_addr,     RESET_PC + 64'd8);
    next_cycle(1);
    check("t2_addr_held",  imem_addr,     RESET_PC + 64'd8);
    gnt_en = 1'b1;
    next_cycle(10);
    expect_stream("t2", RESET_PC, 4);

    // ---- Redirect vectors ----
    for (int v = 0; v < 3; v++) begin
      lat      = vecs[v].lat;
      id_ready = 1'b1;
      do_reset();
      next_cycle(2);
      check({vecs[v].name, "_idv_before"}, 64'(id_valid), 64'(vecs[v].exp_idv_before));
      redirect_valid = 1'b1;
      redirect_pc    = vecs[v].rpc;
      clear_logs();
      #1;
      check({vecs[v].name, "_idv_redir"}, 64'(id_valid), 64'd0);
      check({vecs[v].name, "_req_redir"}, 64'(imem_req), 64'd0);
      @(negedge clk);
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      #1;
      check({vecs[v].name, "_next_addr"}, imem_addr,          vecs[v].exp_pc);
      check({vecs[v].name, "_flushed"},   64'(id_valid),      64'd0);
      check({vecs[v].name, "_no_pop"},    64'(dq_addr.size()), 64'd0);
      next_cycle(16);
      expect_stream(vecs[v].name, vecs[v].exp_pc, 3);
    end

    // ---- Back-to-back redirects with one fetch outstanding ----
    lat = 3;
    do_reset();
    next_cycle(1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_8000_2000;
    #1;
    check("t5_req_redir1", 64'(imem_req), 64'd0);
    @(negedge clk);
    #1;
    check("t5_addr_redir1", imem_addr, 64'h0000_0000_8000_2000);
    redirect_pc = 64'h0000_0000_8000_3000;
    clear_logs();
    #1;
    check("t5_req_redir2", 64'(imem_req), 64'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1;
    check("t5_addr_redir2", imem_addr, 64'h0000_0000_8000_3000);
    next_cycle(16);
    check("t5_grants", 64'(gq.size() >= 1), 64'd1);
    if (gq.size() >= 1) check("t5_first_grant", gq[0], 64'h0000_0000_8000_3000);
    expect_stream("t5", 64'h0000_0000_8000_3000, 3);
`ifdef IF_PERF_CNT_EN
    check("t5_redirect_cnt", redirect_cnt, 64'd2);
`endif

    // ---- Reset mid-stream with two fetches outstanding ----
    lat = 3;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      next_cycle(1);
      if (pq_addr.size() == 2 && dq_addr.size() >= 1) break;
    end
    check("t6_two_outstanding", 64'(pq_addr.size()), 64'd2);
`ifdef IF_PERF_CNT_EN
    check("t6_fetch_cnt_live", fetch_cnt, 64'(dq_addr.size()));
`endif
    rst = 1'b1;
    #1;
    check("t6_req_in_rst", 64'(imem_req), 64'd0);
    check("t6_idv_in_rst", 64'(id_valid), 64'd0);
    next_cycle(1);
    check("t6_req_after",  64'(imem_req), 64'd0);
    check("t6_idv_after",  64'(id_valid), 64'd0);
    check("t6_inst_after", 64'(inst),     64'd0);
    check("t6_addr_after", inst_addr,     64'd0);
`ifdef IF_PERF_CNT_EN
    check("t6_fetch_cnt",    fetch_cnt,    64'd0);
    check("t6_redirect_cnt", redirect_cnt, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    #1;
    check("t6_req_restart",  64'(imem_req), 64'd1);
    check("t6_addr_restart", imem_addr,     RESET_PC);
    next_cycle(16);
    expect_stream("t6", RESET_PC, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
